nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Multi-cycle controller that sequences a single 4-bit carry-chained adder slice across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
- Trades latency for area in place of a full-width ripple adder.
- Provides start/busy/done handshake, add/subtract mode, carry-out and signed-overflow flags.
- Sits between a requesting control unit and result consumers; operands are captured once, so requesters may change them after start.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B+Ci; 1 = A-B (A + ~B + 1, Ci ignored); captured with start.
- Ci  input  1  carry-in for add mode; captured with start.
- A  input  WIDTH  operand A; captured with start.
- B  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- Sum  output  WIDTH  result register.
- Cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0; nibble index, carry and operand registers cleared. Reset takes priority over everything.
- Reset mid-operation aborts the operation: no done pulse, results are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture opA=A, opB=(sub ? ~B : B), carry=(sub ? 1 : Ci), idx=0; go to RUN. With start=0, stay in IDLE.
- RUN, each edge:
  - nib = opA[idx] + opB[idx] + carry (5-bit result);
  - write the low 4 bits into partial[idx]; carry = bit 4; idx++.
  - On the edge processing idx=NIB-1: Sum=full partial, Cout=final carry, Ovf=c_in(MSB) ^ c_out(MSB) computed inside the last nibble; go to DONE.
  - start is ignored while in RUN.
- DONE: done=1 for exactly this one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge E0 → busy=1 during cycles E0..E(NIB-1) → done=1 in the cycle after edge E(NIB). For WIDTH=16: done is high 4 cycles after the start edge.
- Throughput: one operation every NIB+1 cycles.
- Sum, Cout and Ovf change only on the completing edge (or reset). They hold through IDLE and through the next operation until that operation completes.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Operand or sub changes after the capture edge have no effect on the operation in flight.
- done and busy are never high simultaneously.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, sub=0, Ci=0, start pulse → busy for 4 cycles, done pulse 4 cycles after start edge; Sum=0x5555, Cout=0, Ovf=0.
- A=0xFFFF, B=0x0001, Ci=0 → Sum=0x0000, Cout=1, Ovf=0. Repeat with A=0x7FFF, B=0x0001 → Sum=0x8000, Cout=0, Ovf=1. Repeat with A=0x0000, B=0x0000, Ci=1 → Sum=0x0001.
- sub=1, A=0x0005, B=0x0007 → Sum=0xFFFE, Cout=0 (borrow). Then A=0x8000, B=0x0001 → Sum=0x7FFF, Cout=1, Ovf=1.
- Start A=0x1111, B=0x1111; during RUN assert start with A=0xFFFF and change A/B → second start ignored; result Sum=0x2222; prior Sum held stable until the completing edge.
- Back-to-back: start held high continuously → accepted in IDLE and again in each DONE cycle; done pulses every 5 cycles with correct results for each captured operand pair.
- rst=1 on the 2nd RUN cycle → next cycle busy=0, done=0, Sum=0, state IDLE; no done pulse follows. A fresh start then completes normally.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: one 4-bit carry-chained slice reused across
// WIDTH bits, LSB nibble first, with start/busy/done handshake.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             Ci,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   partial_q, partial_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // The single shared 4-bit slice; operands shift down so the live nibble is always [3:0].
  logic [4:0]         nib_c;
  logic               msb_cin_c;
  logic               last_c;

  assign nib_c  = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]} + {4'b0, carry_q};
  // Carry into bit 3 of the slice, recovered from the sum bit instead of a second adder.
  assign msb_cin_c = opa_q[3] ^ opb_q[3] ^ nib_c[3];
  assign last_c    = (idx_q == IDX_W'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Ci;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Result nibbles enter from the top so after NIB steps partial is LSB-aligned.
        partial_d = {nib_c[3:0], partial_q[WIDTH-1:4]};
        opa_d     = {4'b0, opa_q[WIDTH-1:4]};
        opb_d     = {4'b0, opb_q[WIDTH-1:4]};
        carry_d   = nib_c[4];
        idx_d     = idx_q + IDX_W'(1);
        if (last_c) begin
          sum_d   = {nib_c[3:0], partial_q[WIDTH-1:4]};
          cout_d  = nib_c[4];
          ovf_d   = msb_cin_c ^ nib_c[4];
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule
